// File: rtl/ram_nibble_clr_if.sv
// Request/response bundle for ram_nibble_clr: request channel, clear control and read-back strobe.
interface ram_nibble_clr_if #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned NIBBLES = 6
);
    localparam int unsigned WIDTH = 4 * NIBBLES;

    logic               clear;
    logic               busy;
    logic               req_valid;
    logic               req_ready;
    logic [ADDR_W-1:0]  req_addr;
    logic [NIBBLES-1:0] req_we;
    logic [WIDTH-1:0]   req_data;
    logic               rd_valid;
    logic [WIDTH-1:0]   rd_data;

    modport master (
        output clear, req_valid, req_addr, req_we, req_data,
        input  busy, req_ready, rd_valid, rd_data
    );

    modport slave (
        input  clear, req_valid, req_addr, req_we, req_data,
        output busy, req_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/ram_nibble_clr.sv
// Single-port RAM with per-nibble write enables, read-first registered read data,
// and a hardware clear sweep that walks every word once after reset or on request.
module ram_nibble_clr #(
    parameter int unsigned           ADDR_W         = 14,
    parameter int unsigned           NIBBLES        = 6,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [4*NIBBLES-1:0]  CLEAR_VALUE    = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    ram_nibble_clr_if.slave  bus
);
    localparam int unsigned WIDTH = 4 * NIBBLES;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_cnt;
    logic [ADDR_W-1:0]  w_cnt_nxt;
    logic               w_sweep_we;
    logic               w_accept;
    logic               r_busy;
    logic               r_rd_valid;
    logic [WIDTH-1:0]   r_rd_data;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    assign w_accept      = bus.req_valid && !r_busy;
    assign bus.req_ready = !r_busy;
    assign bus.busy      = r_busy;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;

    // Next-state: the sweep ends on the word whose counter value is all ones.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sweep_we  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.clear) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                w_sweep_we = 1'b1;
                w_cnt_nxt  = r_cnt + ADDR_W'(1);
                if (&r_cnt) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= RST_STATE;
            r_cnt      <= '0;
            r_busy     <= CLEAR_ON_RESET;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy     <= (w_state_nxt == S_CLEAR);
            r_rd_valid <= w_accept;
            if (w_accept) begin
                r_rd_data <= r_mem[bus.req_addr];
            end
        end
    end

    // Storage is deliberately not reset; only the sweep initialises it.
    always_ff @(posedge clk) begin
        if (w_sweep_we) begin
            r_mem[r_cnt] <= CLEAR_VALUE;
        end else if (w_accept) begin
            for (int unsigned k = 0; k < NIBBLES; k++) begin
                if (bus.req_we[k]) begin
                    r_mem[bus.req_addr][4*k +: 4] <= bus.req_data[4*k +: 4];
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_nibble_clr.sv
// Self-checking bench for ram_nibble_clr: directed vectors, an abstract memory/busy model
// compared every cycle, and literal expectations for the key scenarios.
module tb_ram_nibble_clr;
    localparam int unsigned AW = 4;
    localparam int unsigned NB = 6;
    localparam int unsigned D  = 16;
    localparam logic [23:0] CV = 24'hA5A5A5;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    ram_nibble_clr_if #(.ADDR_W(AW), .NIBBLES(NB)) bus ();

    ram_nibble_clr #(
        .ADDR_W(AW), .NIBBLES(NB), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    // Model: memory image with per-word "known" flags, remaining sweep cycles, pending read.
    logic [23:0] m_mem [D];
    bit          m_known [D];
    int          m_busy_left;
    bit          m_rdv;
    logic [23:0] m_rdd;
    bit          m_rdk;
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy_left = D;
        m_rdv = 1'b0;
        m_rdd = '0;
        m_rdk = 1'b1;
        for (int i = 0; i < D; i++) m_known[i] = 1'b0;
    endtask

    // One rising edge of the specified behaviour, evaluated from the inputs held across it.
    task automatic model_step();
        bit acc;
        int a;
        acc = bus.req_valid && (m_busy_left == 0);
        a   = int'(bus.req_addr);
        if (acc) begin
            m_rdd = m_mem[a];
            m_rdk = m_known[a];
            for (int k = 0; k < NB; k++)
                if (bus.req_we[k]) m_mem[a][4*k +: 4] = bus.req_data[4*k +: 4];
            if (&bus.req_we) m_known[a] = 1'b1;
        end
        m_rdv = acc;
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0)
                for (int i = 0; i < D; i++) begin
                    m_mem[i]   = CV;
                    m_known[i] = 1'b1;
                end
        end else if (bus.clear) begin
            m_busy_left = D;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
    endtask

    task automatic drive(input bit v, input logic [3:0] a, input logic [5:0] we,
                         input logic [23:0] d, input bit clr);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_we    = we;
        bus.req_data  = d;
        bus.clear     = clr;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(bus.busy), 32'(m_busy_left > 0));
            check("req_ready", 32'(bus.req_ready), 32'(m_busy_left == 0));
            check("rd_valid", 32'(bus.rd_valid), 32'(m_rdv));
            if (m_rdk) check("rd_data", 32'(bus.rd_data), 32'(m_rdd));
        end
    end

    initial begin
        int n;
        for (int i = 0; i < D; i++) m_mem[i] = 'x;
        drive(0, 0, 0, 0, 0);
        #1 reset_n = 1'b0;
        model_reset();
        chk_en = 1'b1;
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 1);
        check("rst_rd_valid", 32'(bus.rd_valid), 0);
        check("rst_rd_data", 32'(bus.rd_data), 0);

        // Power-up sweep length and contents
        reset_n = 1'b1;
        n = 0;
        while (bus.busy && n < 40) begin tick(); n++; end
        check("rst_sweep_len", 32'(n), 16);
        for (int a = 0; a < D; a++) begin
            drive(1, 4'(a), 0, 0, 0);
            tick();
            check("sweep_rd", 32'(bus.rd_data), 32'(CV));
        end

        // Read-first write, then read back
        drive(1, 4'd3, 6'h3F, 24'h123456, 0);
        tick();
        check("wr3_valid", 32'(bus.rd_valid), 1);
        check("wr3_rd_first", 32'(bus.rd_data), 32'(24'hA5A5A5));
        drive(1, 4'd3, 6'h00, 24'h0, 0);
        tick();
        check("rd3_full", 32'(bus.rd_data), 32'(24'h123456));

        // Partial nibble write
        drive(1, 4'd3, 6'b000101, 24'hFFFFFF, 0);
        tick();
        drive(1, 4'd3, 6'h00, 24'h0, 0);
        tick();
        check("rd3_partial", 32'(bus.rd_data), 32'(24'h123F5F));

        // Back-to-back reads
        drive(1, 4'd1, 6'h3F, 24'h111111, 0); tick();
        drive(1, 4'd2, 6'h3F, 24'h222222, 0); tick();
        drive(1, 4'd1, 6'h00, 24'h0, 0); tick();
        check("b2b_1", 32'(bus.rd_data), 32'(24'h111111));
        drive(1, 4'd2, 6'h00, 24'h0, 0); tick();
        check("b2b_2", 32'(bus.rd_data), 32'(24'h222222));
        drive(1, 4'd3, 6'h00, 24'h0, 0); tick();
        check("b2b_3", 32'(bus.rd_data), 32'(24'h123F5F));
        check("b2b_valid", 32'(bus.rd_valid), 1);
        drive(0, 0, 0, 0, 0); tick();
        check("idle_valid", 32'(bus.rd_valid), 0);
        check("idle_hold", 32'(bus.rd_data), 32'(24'h123F5F));

        // Clear with a simultaneous write; requests and re-clears ignored while busy
        drive(1, 4'd5, 6'h3F, 24'h555555, 1);
        tick();
        check("clr_wr_valid", 32'(bus.rd_valid), 1);
        check("clr_wr_data", 32'(bus.rd_data), 32'(CV));
        check("clr_busy_rise", 32'(bus.busy), 1);
        n = 0;
        while (bus.busy && n < 40) begin
            drive(1, 4'd5, 6'h3F, 24'h0, (n < 3) ? 1'b1 : 1'b0);
            tick();
            n++;
            check("busy_no_rd", 32'(bus.rd_valid), 0);
        end
        check("clr_sweep_len", 32'(n), 16);
        drive(1, 4'd5, 6'h00, 24'h0, 0);
        tick();
        check("rd5_cleared", 32'(bus.rd_data), 32'(CV));

        // Reset in the middle of a sweep restarts a full sweep
        drive(0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0);
        repeat (7) tick();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midrst_busy", 32'(bus.busy), 1);
        repeat (2) tick();
        reset_n = 1'b1;
        n = 0;
        while (bus.busy && n < 40) begin tick(); n++; end
        check("midrst_sweep_len", 32'(n), 16);
        drive(1, 4'd3, 6'h00, 24'h0, 0);
        tick();
        check("rd3_after_rst", 32'(bus.rd_data), 32'(CV));
        drive(0, 0, 0, 0, 0);
        tick();
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ram_nibble_clr.md
RAM_NIBBLE_CLR -- requirements
Module: ram_nibble_clr

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, address width; DEPTH = 2**ADDR_W words.
REQ-002 SHALL have parameter NIBBLES, default 6, number of 4-bit write lanes; WIDTH = 4*NIBBLES bits.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = run clear sweep after reset release, 0 = start idle.
REQ-004 SHALL have parameter CLEAR_VALUE, default 0, WIDTH-bit word written by the clear sweep.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 clear  input  1  pulse; starts a clear sweep when idle.
REQ-009 busy  output  1  high while the clear sweep runs.
REQ-010 req_valid  input  1  access request.
REQ-011 req_ready  output  1  request may be accepted; equals !busy (combinational).
REQ-012 req_addr  input  ADDR_W  word address.
REQ-013 req_we  input  NIBBLES  per-nibble write enable; bit k covers data bits [4k+3:4k].
REQ-014 req_data  input  WIDTH  write data.
REQ-015 rd_valid  output  1  one-cycle strobe; rd_data is valid.
REQ-016 rd_data  output  WIDTH  registered read data.

Function
REQ-017 SHALL accept a request on a rising edge where req_valid && req_ready; no other request has effect.
REQ-018 SHALL, on acceptance, write req_data nibble k into word req_addr for every set req_we[k] and leave unselected nibbles unchanged.
REQ-019 SHALL, on every acceptance (read or write), register the word at req_addr as it was before that edge's write (read-first) into rd_data.
REQ-020 SHALL assert rd_valid exactly one cycle after each acceptance, for one cycle; latency = 1 clock.
REQ-021 SHALL hold rd_data unchanged while rd_valid is low.
REQ-022 SHALL sustain one acceptance per cycle; back-to-back requests produce back-to-back rd_valid.
REQ-023 SHALL implement states IDLE and CLEAR with an ADDR_W-bit sweep counter.
REQ-024 SHALL, in IDLE with clear high, enter CLEAR with counter = 0 on that edge; a request accepted on the same edge still completes.
REQ-025 SHALL, in CLEAR, write CLEAR_VALUE to all nibbles of word[counter] each cycle and increment counter.
REQ-026 SHALL, after writing word DEPTH-1, return to IDLE; busy is high for exactly DEPTH cycles.
REQ-027 SHALL ignore clear while in CLEAR; the sweep does not restart.
REQ-028 SHALL drive busy = 1 in CLEAR and 0 in IDLE, as a registered state decode.
REQ-029 SHALL treat the counter wrap (DEPTH-1 to 0) as the termination condition; the counter does not overflow into extra writes.
REQ-030 SHALL ignore req_valid while busy; no write and no rd_valid result.
REQ-031 SHALL, for req_we = 0, perform a pure read.

Reset
REQ-032 SHALL, while reset_n is low, force rd_valid = 0, rd_data = 0 and counter = 0.
REQ-033 SHALL force state to CLEAR (busy = 1) if CLEAR_ON_RESET = 1, else IDLE (busy = 0).
REQ-034 SHALL NOT reset memory contents directly; only the clear sweep initialises them.
REQ-035 SHALL, on reset asserted mid-sweep, abandon the sweep and restart per REQ-033 after release; partially cleared words are not guaranteed.
REQ-036 SHALL drop an accepted-but-unreported read if reset asserts before rd_valid; rd_valid stays 0.

Verification (ADDR_W=4, NIBBLES=6, CLEAR_VALUE=24'hA5A5A5)
REQ-037 Release reset -> busy = 1 for exactly 16 cycles, then 0; reads of addrs 0..15 return 24'hA5A5A5.
REQ-038 Write addr 3 data 24'h123456 we=6'b111111, then read 3 -> write returns 24'hA5A5A5 (read-first); read returns 24'h123456 one cycle after acceptance.
REQ-039 Write addr 3 data 24'hFFFFFF we=6'b000101, read 3 -> 24'h123F5F.
REQ-040 Pulse clear together with a write to addr 5 -> write accepted, busy rises next cycle; after 16 cycles addr 5 reads 24'hA5A5A5; req_valid held during busy -> no rd_valid.
REQ-041 Assert reset_n low at sweep cycle 7 -> busy stays high; after release, busy high for a full 16 cycles.
REQ-042 Reads to addrs 1,2,3 on consecutive cycles -> rd_valid high three consecutive cycles with data in request order.
